alu_req_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU (ADD/SUB/AND/OR/XOR/XNOR/SHL/SHR, 3-bit opcode) between two requesters using valid/ready handshakes.
- Grants requesters round-robin, registers the granted operands and opcode, and drives the ALU for one cycle.
- Captures result, carry and zero flag, then returns them only to the owning requester.
- Sits between the tile's operand sources and the existing ALU instance; the ALU stays outside this block.

---
 rtl/alu_req_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester valid/ready front end for a shared combinational ALU: arbitrates,
// registers operands for one EXEC cycle and returns the captured result to the owner.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module alu_req_arbiter #(
  parameter int DW  = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_carry,
  output logic           rsp_zero,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_carry,
  input  logic           alu_zero,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_grant_q, last_grant_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  result_q, result_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           idle;
  logic           win1;
  logic           owner_rsp_ready;

  assign idle = (state_q == IDLE);

  // win1: requester 1 is the arbitration winner this cycle.
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win1 = req1_valid & ~req0_valid;
`else
  assign win1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif

  // Readies are gated by rst_n so nothing looks accepted while reset is held.
  assign req0_ready = rst_n & idle & req0_valid & ~win1;
  assign req1_ready = rst_n & idle & win1;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          owner_d      = win1;
          last_grant_d = win1;
          a_d          = win1 ? req1_a  : req0_a;
          b_d          = win1 ? req1_b  : req0_b;
          op_d         = win1 ? req1_op : req0_op;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        carry_d  = alu_carry;
        zero_d   = alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;
  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) &  owner_q;
  assign busy       = ~idle;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter; a tiny behavioural ALU stands in for the
// external ALU and every expected value below is hand-computed.
module tb_alu_req_arbiter;
  localparam int DW  = 4;
  localparam int OPW = 3;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0]  rsp_result;
  logic           rsp_carry, rsp_zero;
  logic [DW-1:0]  alu_a, alu_b, alu_result;
  logic [OPW-1:0] alu_op;
  logic           alu_carry, alu_zero;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .busy(busy)
  );

  // Stand-in ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 SHL, 111 SHR.
  always_comb begin
    alu_carry  = 1'b0;
    alu_result = '0;
    case (alu_op)
      3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~(alu_a ^ alu_b);
      3'd6: alu_result = alu_a << 1;
      default: alu_result = alu_a >> 1;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic r, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    if (r) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
  endtask

  // One complete transaction with rsp_ready held high; starts at a negedge in IDLE.
  task automatic run_op(input string tag, input logic r, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] er, input logic ec, input logic ez);
    @(negedge clk);
    set_req(r, a, b, op);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1 check({tag, "_ready"}, r ? req1_ready : req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check({tag, "_exec_busy"}, busy, 1);
    check({tag, "_exec_rsp"}, {rsp0_valid, rsp1_valid}, 0);
    check({tag, "_alu_in"}, {alu_a, alu_b, alu_op}, {a, b, op});
    @(negedge clk);
    #1;
    check({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, r ? 2'b10 : 2'b01);
    check({tag, "_result"}, {rsp_result, rsp_carry, rsp_zero}, {er, ec, ez});
    @(negedge clk);
    #1 check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;

    // Reset state, with both requesters asserting valid.
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_outs", {rsp0_valid, rsp1_valid, busy, rsp_result, rsp_carry, rsp_zero}, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: grants alternate 0,1,0,1 (round-robin) or stay on 0 (fixed).
    set_req(0, 4'b1100, 4'b1010, 3'b010);
    set_req(1, 4'b1111, 4'b1111, 3'b100);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = RR ? i[0] : 1'b0;
      #1 check($sformatf("cont%0d_grant", i), {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
      @(negedge clk);
      #1 check($sformatf("cont%0d_exec_ready", i), {req0_ready, req1_ready}, 0);
      @(negedge clk);
      #1;
      check($sformatf("cont%0d_rsp", i), {rsp1_valid, rsp0_valid}, g ? 2'b10 : 2'b01);
      check($sformatf("cont%0d_res", i), {rsp_result, rsp_zero}, g ? 5'b0000_1 : 5'b1000_0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    run_op("add", 0, 4'd9, 4'd8, 3'b000, 4'd1, 1'b1, 1'b0);

    // Backpressure on requester 1; requester 0 and rsp0_ready must be ignored.
    @(negedge clk);
    set_req(1, 4'd3, 4'd5, 3'b001);
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    #1 check("bp_ready", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    set_req(0, 4'd7, 4'd1, 3'b000);
    #1 check("bp_exec_ready", req0_ready, 0);
    repeat (6) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", {rsp1_valid, rsp0_valid}, 2'b10);
      check("bp_hold_res", {rsp_result, rsp_carry, rsp_zero}, {4'b1110, 1'b0, 1'b0});
      check("bp_hold_ready", {req0_ready, req1_ready}, 0);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    #1 check("bp_last_valid", rsp1_valid, 1);
    @(negedge clk);
    #1 check("bp_done", {busy, rsp1_valid}, 0);

    run_op("shl", 0, 4'b1001, 4'b0000, 3'b110, 4'b0010, 1'b0, 1'b0);
    run_op("shr", 0, 4'b0001, 4'b0000, 3'b111, 4'b0000, 1'b0, 1'b1);

    // Withdrawn request from requester 1 while requester 0 owns RESP.
    @(negedge clk);
    set_req(0, 4'b0101, 4'b0011, 3'b011);
    rsp0_ready = 1'b0;
    #1 check("wd_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    set_req(1, 4'd2, 4'd2, 3'b000);
    #1 check("wd_req1_blocked", req1_ready, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    #1 check("wd_rsp", {rsp0_valid, rsp_result}, {1'b1, 4'b0111});
    @(negedge clk);
    #1 check("wd_idle", {busy, rsp1_valid}, 0);
    @(negedge clk);
    #1 check("wd_no_accept", busy, 0);
    set_req(0, 4'd1, 4'd1, 3'b000);
    set_req(1, 4'd1, 4'd1, 3'b000);
    #1 check("wd_next_grant", {req1_ready, req0_ready}, RR ? 2'b10 : 2'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset while in EXEC.
    @(negedge clk);
    set_req(1, 4'b1111, 4'b0110, 3'b010);
    rsp1_ready = 1'b1;
    #1 check("rexec_ready", req1_ready, 1);
    @(negedge clk);
    #1;
    set_req(0, 4'd1, 4'd1, 3'b000);
    rst_n = 1'b0;
    #1;
    check("rexec_outs", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
    check("rexec_data", {rsp_result, rsp_carry, rsp_zero, alu_a, alu_b, alu_op}, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 check("rexec_no_rsp", {busy, rsp0_valid, rsp1_valid}, 0);
    end
    set_req(0, 4'd1, 4'd1, 3'b000);
    set_req(1, 4'd1, 4'd1, 3'b000);
    #1 check("rexec_grant", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset while in RESP after a requester-0 grant.
    @(negedge clk);
    set_req(0, 4'b1111, 4'b0001, 3'b000);
    rsp0_ready = 1'b0;
    #1 check("rresp_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1 check("rresp_rsp", {rsp0_valid, rsp_result, rsp_carry, rsp_zero}, {1'b1, 4'b0000, 1'b1, 1'b1});
    rst_n = 1'b0;
    #1 check("rresp_outs", {busy, rsp0_valid, rsp_carry, rsp_zero, alu_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 check("rresp_no_rsp", {busy, rsp0_valid, rsp1_valid}, 0);
    end
    set_req(0, 4'd1, 4'd1, 3'b000);
    set_req(1, 4'd1, 4'd1, 3'b000);
    #1 check("rresp_grant", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
